// File: rtl/adder_share_arbiter.sv
// Round-robin front end sharing one external combinational adder among NREQ requesters.
// Result valid two edges after the request handshake; no new grant until the owner takes its result.
module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH:0]        resp_sum,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_c0,
  input  logic [WIDTH:0]        add_s,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c0_q, c0_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic             found;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_c;
  int               idx;

  // Winner: first valid requester scanning from ptr upward, wrapping at NREQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
        sel_c = req_cin[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    c0_d    = c0_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = sel_a;
          b_d     = sel_b;
          c0_d    = sel_c;
          id_d    = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sum_d   = add_s;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready[id_q]) begin
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c0_q    <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c0_q    <= c0_d;
      sum_q   <= sum_d;
    end
  end

  // Gated by rst so no grant is advertised while reset is held.
  assign req_ready  = (state_q == IDLE && found && !rst) ? (NREQ'(1) << grant_idx) : '0;
  assign resp_valid = (state_q == RESP) ? (NREQ'(1) << id_q) : '0;
  assign resp_sum   = sum_q;
  assign resp_id    = id_q;
  assign add_a      = a_q;
  assign add_b      = b_q;
  assign add_c0     = c0_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural adder on the add_* ports.
module tb_adder_share_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_cin, resp_valid, resp_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH:0]        resp_sum, add_s;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      add_a, add_b;
  logic                  add_c0, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon2   = 1'b0;
  bit seen2  = 1'b0;

  adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_id(resp_id),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_s(add_s),
    .busy(busy)
  );

  assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (mon2 && resp_valid[2]) seen2 = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (resp_valid == '0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 64'(resp_valid != '0), 64'd1);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = c;
  endtask

  initial begin
    logic [32:0] rr_sum [4];
    int          rr_order [5];
    int          got, n, last_cyc;

    rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; req_cin = '0;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_sum", resp_sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    @(negedge clk); rst = 1'b0;

    // Single request with latency check
    @(negedge clk);
    set_op(0, 32'h5, 32'h3, 1'b1);
    req_valid = 4'b0001;
    #1 chk("t1_req_ready", req_ready, 4'b0001);
    @(negedge clk); req_valid = '0;
    #1 chk("t1_issue_resp_valid", resp_valid, 0);
    chk("t1_issue_busy", busy, 1);
    chk("t1_add_a", add_a, 32'h5);
    @(negedge clk); #1;
    chk("t1_resp_valid", resp_valid, 4'b0001);
    chk("t1_resp_sum", resp_sum, 33'h0_0000_0009);
    chk("t1_resp_id", resp_id, 0);
    resp_ready = 4'b1111;
    @(negedge clk); #1;
    chk("t1_done_busy", busy, 0);

    // Carry-out
    set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0);
    req_valid = 4'b0100;
    #1 chk("t2_req_ready", req_ready, 4'b0100);
    @(negedge clk); req_valid = '0;
    #1 wait_resp("t2_timeout");
    chk("t2_resp_valid", resp_valid, 4'b0100);
    chk("t2_resp_sum", resp_sum, 33'h1_0000_0000);
    chk("t2_resp_id", resp_id, 2);
    @(negedge clk);

    // Round robin from ptr=0
    rst = 1'b1; #1 rst = 1'b0;
    set_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_op(1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    set_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    set_op(3, 32'h1234_5678, 32'h1111_1111, 1'b0);
    rr_sum[0] = 33'h0_0000_0030;
    rr_sum[1] = 33'h1_0000_0001;
    rr_sum[2] = 33'h0_8000_0001;
    rr_sum[3] = 33'h0_2345_6789;
    rr_order = '{0, 1, 2, 3, 0};
    resp_ready = 4'b1111;
    req_valid  = 4'b1111;
    got = 0; n = 0; last_cyc = 0;
    while (got < 5 && n < 60) begin
      @(negedge clk); #1;
      n++;
      if (resp_valid != '0) begin
        chk("rr_id", resp_id, rr_order[got]);
        chk("rr_valid", resp_valid, 4'(1) << rr_order[got]);
        chk("rr_sum", resp_sum, rr_sum[rr_order[got]]);
        if (got > 0) chk("rr_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        got++;
        if (got == 5) req_valid = '0;
      end
    end
    chk("rr_count", got, 5);
    @(negedge clk);

    // Backpressure on requester 1 (ptr=1); other resp_ready bits high and ignored
    set_op(1, 32'hA, 32'hB, 1'b0);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    #1 chk("bp_req_ready", req_ready, 4'b0010);
    @(negedge clk); req_valid = '0;
    #1 wait_resp("bp_timeout");
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_resp_valid", resp_valid, 4'b0010);
      chk("bp_resp_sum", resp_sum, 33'h15);
      chk("bp_resp_id", resp_id, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    resp_ready = 4'b0010;
    @(negedge clk); #1;
    chk("bp_done_valid", resp_valid, 0);
    chk("bp_done_busy", busy, 0);
    chk("bp_next_grant", req_ready, 4'b0001);
    req_valid = '0;

    // Async reset mid-RESP (ptr=2)
    resp_ready = '0;
    set_op(3, 32'h100, 32'h200, 1'b0);
    set_op(0, 32'h1, 32'h1, 1'b0);
    @(negedge clk); req_valid = 4'b1000;
    @(negedge clk); req_valid = '0;
    #1 wait_resp("ar_timeout");
    chk("ar_pre_valid", resp_valid, 4'b1000);
    req_valid = 4'b1001;
    #2 rst = 1'b1;
    #1;
    chk("ar_resp_valid", resp_valid, 0);
    chk("ar_req_ready", req_ready, 0);
    chk("ar_resp_sum", resp_sum, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("ar_grant0", req_ready, 4'b0001);
    resp_ready = 4'b1111;
    @(negedge clk); req_valid = '0;
    #1 wait_resp("ar2_timeout");
    chk("ar_resp_id", resp_id, 0);
    chk("ar_resp_sum2", resp_sum, 33'h2);
    @(negedge clk);

    // Withdrawal of requester 2 (ptr=1)
    mon2 = 1'b1;
    set_op(1, 32'h7, 32'h8, 1'b1);
    req_valid = 4'b0110;
    #1 chk("wd_req_ready", req_ready, 4'b0010);
    @(negedge clk); req_valid = '0;
    #1 wait_resp("wd_timeout");
    chk("wd_resp_id", resp_id, 1);
    chk("wd_resp_sum", resp_sum, 33'h10);
    repeat (10) @(negedge clk);
    #1;
    chk("wd_never2", seen2, 0);
    chk("wd_idle_valid", resp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
